// File: rtl/iir_mc_pkg.sv
// iir_mc_pkg: shared types, tap ordering and arithmetic helpers for the
// time-shared biquad.
package iir_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Tap order within one channel's MAC sequence.
  localparam int         NUM_TAPS = 5;
  localparam logic [2:0] TAP_B0   = 3'd0;
  localparam logic [2:0] TAP_B1   = 3'd1;
  localparam logic [2:0] TAP_B2   = 3'd2;
  localparam logic [2:0] TAP_A1   = 3'd3;
  localparam logic [2:0] TAP_A2   = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Three guard bits cover the sum of five full-scale products.
  function automatic int acc_wid(input int in_wid, input int out_wid, input int coef_wid);
    return max_int(in_wid, out_wid) + coef_wid + 3;
  endfunction

  // Round half up, arithmetic shift, then clamp or wrap to out_wid bits.
  // Works on a 64-bit signed carrier; the caller truncates to out_wid.
  function automatic logic signed [63:0] round_resize(input logic signed [63:0] acc,
                                                      input int frac,
                                                      input int out_wid,
                                                      input bit sat);
    logic signed [63:0] rnd;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    rnd = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi  = (64'sd1 <<< (out_wid - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_wid - 1));
    if (sat) begin
      if (rnd > hi)      res = hi;
      else if (rnd < lo) res = lo;
      else               res = rnd;
    end else begin
      res = (rnd <<< (64 - out_wid)) >>> (64 - out_wid);
    end
    return res;
  endfunction

endpackage

// File: rtl/iir_mc_mac.sv
// iir_mc_mac: single multiplier plus accumulator shared by all channels and
// taps, with the round/resize output stage. Build macro IIR_MC_SAT_EN selects
// saturation; otherwise the result wraps.
module iir_mc_mac
  import iir_mc_pkg::*;
#(
  parameter int COEF_WID  = 16,
  parameter int DATA_WID  = 10,
  parameter int ACC_WID   = 29,
  parameter int COEF_FRAC = 14,
  parameter int OUT_WID   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       acc_clr_i,
  input  logic                       acc_en_i,
  input  logic                       neg_i,
  input  logic signed [COEF_WID-1:0] coef_i,
  input  logic signed [DATA_WID-1:0] data_i,
  output logic signed [OUT_WID-1:0]  res_o
);

  localparam int PROD_WID = COEF_WID + DATA_WID;

`ifdef IIR_MC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic signed [PROD_WID-1:0] prod;
  logic signed [ACC_WID-1:0]  term;
  logic signed [ACC_WID-1:0]  sum;
  logic signed [ACC_WID-1:0]  acc_q;
  logic signed [ACC_WID-1:0]  acc_d;

  // Product feeds the adder directly; the result reflects the current tap too.
  always_comb begin
    prod  = PROD_WID'(coef_i) * PROD_WID'(data_i);
    term  = ACC_WID'(prod);
    if (neg_i) term = -term;
    sum   = acc_q + term;
    acc_d = acc_q;
    if (acc_clr_i)     acc_d = '0;
    else if (acc_en_i) acc_d = sum;
    res_o = OUT_WID'(round_resize(64'(sum), COEF_FRAC, OUT_WID, SAT));
  end

  // Accumulator register; clear wins over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/iir_mc.sv
// iir_mc: multi-channel time-shared DF-I biquad with valid/ready on both
// sides. Build macro IIR_MC_SAT_EN enables output saturation (default wrap).
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// MAC   | one tap product per cycle, channel after channel
// OUT   | output vector held until out_ready
module iir_mc
  import iir_mc_pkg::*;
#(
  parameter int CH_NUM    = 2,
  parameter int IN_WID    = 10,
  parameter int OUT_WID   = 10,
  parameter int COEF_WID  = 16,
  parameter int COEF_FRAC = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic signed [COEF_WID-1:0]  coef_b0,
  input  logic signed [COEF_WID-1:0]  coef_b1,
  input  logic signed [COEF_WID-1:0]  coef_b2,
  input  logic signed [COEF_WID-1:0]  coef_a1,
  input  logic signed [COEF_WID-1:0]  coef_a2,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH_NUM*IN_WID-1:0]    in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH_NUM*OUT_WID-1:0]   out_data
);

  localparam int              DATA_WID = max_int(IN_WID, OUT_WID);
  localparam int              ACC_WID  = acc_wid(IN_WID, OUT_WID, COEF_WID);
  localparam int              CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CH_NUM - 1);
  localparam logic [2:0]      TAP_LAST = 3'(NUM_TAPS - 1);

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            ch_q;
  logic [2:0]                 step_q;
  logic [CH_NUM*IN_WID-1:0]   samp_q;
  logic signed [IN_WID-1:0]   x1_q [CH_NUM];
  logic signed [IN_WID-1:0]   x2_q [CH_NUM];
  logic signed [OUT_WID-1:0]  y1_q [CH_NUM];
  logic signed [OUT_WID-1:0]  y2_q [CH_NUM];
  logic [CH_NUM*OUT_WID-1:0]  out_q;

  logic                       accept;
  logic                       last_tap;
  logic                       acc_en;
  logic                       acc_clr;
  logic signed [IN_WID-1:0]   x0;
  logic signed [COEF_WID-1:0] mac_coef;
  logic signed [DATA_WID-1:0] mac_data;
  logic                       mac_neg;
  logic signed [OUT_WID-1:0]  mac_res;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and control strobes; clr overrides everything, including accept.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_tap  = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          accept  = 1'b1;
          acc_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_en = 1'b1;
        if (step_q == TAP_LAST) begin
          last_tap = 1'b1;
          acc_clr  = 1'b1;
          if (ch_q == CH_LAST) state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d  = IDLE;
      accept   = 1'b0;
      last_tap = 1'b0;
      acc_en   = 1'b0;
      acc_clr  = 1'b1;
    end
  end

  // Tap operand select for the current channel and step.
  always_comb begin
    x0       = samp_q[ch_q*IN_WID +: IN_WID];
    mac_coef = coef_b0;
    mac_data = DATA_WID'(x0);
    mac_neg  = 1'b0;
    case (step_q)
      TAP_B1: begin
        mac_coef = coef_b1;
        mac_data = DATA_WID'(x1_q[ch_q]);
      end
      TAP_B2: begin
        mac_coef = coef_b2;
        mac_data = DATA_WID'(x2_q[ch_q]);
      end
      TAP_A1: begin
        mac_coef = coef_a1;
        mac_data = DATA_WID'(y1_q[ch_q]);
        mac_neg  = 1'b1;
      end
      TAP_A2: begin
        mac_coef = coef_a2;
        mac_data = DATA_WID'(y2_q[ch_q]);
        mac_neg  = 1'b1;
      end
      default: ;
    endcase
  end

  iir_mc_mac #(
    .COEF_WID  (COEF_WID),
    .DATA_WID  (DATA_WID),
    .ACC_WID   (ACC_WID),
    .COEF_FRAC (COEF_FRAC),
    .OUT_WID   (OUT_WID)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .acc_clr_i (acc_clr),
    .acc_en_i  (acc_en),
    .neg_i     (mac_neg),
    .coef_i    (mac_coef),
    .data_i    (mac_data),
    .res_o     (mac_res)
  );

  // Sample latch, step/channel counters, per-channel history and output slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q   <= '0;
      step_q <= '0;
      samp_q <= '0;
      out_q  <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else if (clr) begin
      ch_q   <= '0;
      step_q <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      if (accept) begin
        samp_q <= in_data;
        ch_q   <= '0;
        step_q <= '0;
      end
      if (acc_en) begin
        if (last_tap) begin
          step_q     <= '0;
          ch_q       <= (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
          x2_q[ch_q] <= x1_q[ch_q];
          x1_q[ch_q] <= x0;
          y2_q[ch_q] <= y1_q[ch_q];
          y1_q[ch_q] <= mac_res;
          out_q[ch_q*OUT_WID +: OUT_WID] <= mac_res;
        end else begin
          step_q <= step_q + 3'd1;
        end
      end
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_iir_mc.sv
// tb_iir_mc: directed vectors with hand-computed results for iir_mc.
module tb_iir_mc;
  localparam int CH_NUM    = 2;
  localparam int IN_WID    = 10;
  localparam int OUT_WID   = 10;
  localparam int COEF_WID  = 16;
  localparam int COEF_FRAC = 14;
  localparam int LAT       = 5 * CH_NUM + 1;

`ifdef IIR_MC_SAT_EN
  localparam int OV_POS = 511;
  localparam int OV_NEG = -512;
`else
  localparam int OV_POS = -2;
  localparam int OV_NEG = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic clr;
  logic signed [COEF_WID-1:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [CH_NUM*IN_WID-1:0]  in_data;
  logic [CH_NUM*OUT_WID-1:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iir_mc #(
    .CH_NUM(CH_NUM), .IN_WID(IN_WID), .OUT_WID(OUT_WID),
    .COEF_WID(COEF_WID), .COEF_FRAC(COEF_FRAC)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
    .coef_a1(coef_a1), .coef_a2(coef_a2),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] och(input int c);
    logic signed [OUT_WID-1:0] v;
    v = out_data[c*OUT_WID +: OUT_WID];
    return 32'(v);
  endfunction

  task automatic set_coef(input int b0, input int b1, input int b2, input int a1, input int a2);
    coef_b0 = COEF_WID'(b0);
    coef_b1 = COEF_WID'(b1);
    coef_b2 = COEF_WID'(b2);
    coef_a1 = COEF_WID'(a1);
    coef_a2 = COEF_WID'(a2);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Returns at #1 after the accepting edge.
  task automatic start_vec(input int x0, input int x1);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = {IN_WID'(x1), IN_WID'(x0)};
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 50), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles from the acceptance cycle (cycle 0 ends at the accepting edge).
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic send(input string tag, input int x0, input int x1, input int e0, input int e1);
    int lat;
    start_vec(x0, x1);
    wait_out(lat);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_ch0"}, och(0), e0);
    check({tag, "_ch1"}, och(1), e1);
  endtask

  initial begin
    int lat;
    int seen;
    int imp_exp [4];
    logic [CH_NUM*OUT_WID-1:0] hold;
    imp_exp = '{128, 64, 32, 16};

    reset     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    set_coef(0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Pass-through
    set_coef(16384, 0, 0, 0, 0);
    send("pass", 100, -200, 100, -200);

    // First-order impulse response, channel 1 held at zero
    do_clr();
    set_coef(8192, 0, 0, -8192, 0);
    for (int i = 0; i < 4; i++) begin
      send("impulse", (i == 0) ? 256 : 0, 0, imp_exp[i], 0);
    end

    // Overflow: saturate or wrap depending on build
    do_clr();
    set_coef(32767, 0, 0, 0, 0);
    send("ovf", 511, -512, OV_POS, OV_NEG);

    // Backpressure with an ignored in_valid pulse
    do_clr();
    set_coef(16384, 0, 0, 0, 0);
    out_ready = 1'b0;
    start_vec(5, -6);
    wait_out(lat);
    check("bp_lat", lat, LAT);
    check("bp_ch0", och(0), 5);
    check("bp_ch1", och(1), -6);
    hold = out_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, out_data}, {1'b1, 1'b0, hold});
      if (i == 5) begin
        in_data  = 20'h12345;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // clr during MAC cycle 3 with nonzero history
    send("hist", 77, -33, 77, -33);
    start_vec(30, 40);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_idle", in_ready, 1);
    check("clr_valid", out_valid, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("clr_no_out", seen, 0);
    set_coef(0, 16384, 0, 0, 0);
    send("clr_x1", 50, 50, 0, 0);
    send("x1_tap", 60, 60, 50, 50);

    // Reset mid-MAC
    start_vec(11, 12);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_rel_ready", in_ready, 1);
    send("post_rst", 70, 80, 0, 0);
    set_coef(16384, 0, 0, 0, 0);
    send("post_rst_pass", -9, 9, -9, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iir_mc.md
# iir_mc

Multi-channel, time-shared biquad IIR filter: one DF-I biquad datapath with a single multiplier, run sequentially over `CH_NUM` independent channels. Each channel keeps its own history. It replaces fixed dual I/Q filter pairs in the front-end filtering chain, between the ADC interface / decimation stage and downstream demodulation. It uses valid/ready handshakes on both sides, per-channel vectors, runtime coefficients, rounding and optional saturation.

## Interface
- `CH_NUM`, 2: number of channels (I/Q = 2); ≥1
- `IN_WID`, 10: signed input sample width
- `OUT_WID`, 10: signed output sample width
- `COEF_WID`, 16: signed coefficient width
- `COEF_FRAC`, 14: coefficient fractional bits (1.0 = 2^COEF_FRAC); 1 ≤ COEF_FRAC < COEF_WID
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `clr`  in  1  synchronous clear of all channel history; aborts any pass in progress
- `coef_b0`, `coef_b1`, `coef_b2`, `coef_a1`, `coef_a2`  in  COEF_WID each  signed coefficients, shared by all channels; must be stable while `in_ready`=0
- `in_valid`  in  1  input vector valid
- `in_ready`  out  1  block can accept a vector
- `in_data`  in  CH_NUM*IN_WID  channel c at bits [c*IN_WID +: IN_WID]
- `out_valid`  out  1  output vector valid
- `out_ready`  in  1  downstream accepts the vector
- `out_data`  out  CH_NUM*OUT_WID  same packing as `in_data`

## Operation
- Per channel: y[n] = (b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2] + 2^(COEF_FRAC-1)) >>> COEF_FRAC.
  - Round-half-up, then an arithmetic shift.
  - y history stores the final OUT_WID result.
- Accumulator: ACC_WID = max(IN_WID, OUT_WID) + COEF_WID + 3, signed. Accumulation never overflows.
- FSM with states IDLE, MAC, OUT:
  - IDLE: `in_ready`=1. On `in_valid`: latch `in_data` into the sample register, set ch=0, step=0, clear acc, go to MAC.
  - MAC: one product per cycle, in the order b0·x0, b1·x1, b2·x2, −a1·y1, −a2·y2 (step 0..4).
    - At step 4: round, shift and resize the result into `out_data` slot ch.
    - Shift channel ch history: x2←x1, x1←x0, y2←y1, y1←y.
    - Clear acc and advance ch.
    - After ch = CH_NUM−1: go to OUT.
  - OUT: `out_valid`=1. `out_data` is stable until `out_valid & out_ready`, then return to IDLE.
- Resize to OUT_WID: saturate or truncate, per the Configuration section.
- `clr` (any state):
  - Zero all x1/x2/y1/y2 history, acc, ch and step; go to IDLE.
  - `out_valid` drops the next cycle. A vector in flight is discarded.
  - `clr` takes priority over `in_valid` in the same cycle.
- `in_valid` is ignored outside IDLE. Upstream must hold the vector until the handshake completes.
- Reset values: `in_ready`=0 while `reset` is asserted, then 1 (IDLE); `out_valid`=0; `out_data`=0; all history, acc, ch and step = 0. Reset mid-pass discards the pass.

## Timing
- Handshake accepted at cycle 0 → MAC occupies cycles 1..5·CH_NUM → `out_valid` is high from cycle 5·CH_NUM+1. With the defaults, `out_valid` rises 11 cycles after acceptance.
- With `out_ready`=1, the OUT→IDLE transition is immediate. `in_ready` rises the cycle after the output handshake.
- Minimum period is 5·CH_NUM+2 cycles per vector.
- Multiplier output feeds the accumulator combinationally; no pipeline register inside MAC.
- History update for channel ch is visible to the next pass only; channels never share history.

## Configuration
- `IIR_MC_SAT_EN` defined: a result outside [−2^(OUT_WID−1), 2^(OUT_WID−1)−1] clamps to the nearest bound. The clamped value is also stored as y history.
- `IIR_MC_SAT_EN` undefined: the low OUT_WID bits are kept (two's-complement wrap). The wrapped value is stored as history.

## Structure
- Package `iir_mc_pkg`:
  - FSM state enum (IDLE, MAC, OUT)
  - tap index constants (TAP_B0..TAP_A2, NUM_TAPS=5)
  - ACC_WID function
  - shared round/resize function (saturate or wrap)
- Sub-module `iir_mc_mac`:
  - signed COEF_WID × max(IN_WID, OUT_WID) multiply, negated for a1/a2 taps
  - accumulate, clear input
  - round/resize output stage
- Top level holds the FSM, channel/step counters, sample and history register arrays, and output packing.

## Test plan
- Pass-through: b0=16384, others 0. Inputs ch0=100, ch1=−200 → `out_data` ch0=100, ch1=−200. `out_valid` rises 11 cycles after acceptance.
- First-order impulse: b0=8192, a1=−8192. Input ch0 256, then 0,0,0 → outputs 128, 64, 32, 16. Ch1 driven with zeros stays 0, confirming channel isolation.
- Overflow: b0=32767, x=511.
  - With `IIR_MC_SAT_EN` → 511.
  - Without it → −2 (1022 wrapped).
  - Likewise x=−512 → −512 saturated.
- Backpressure: hold `out_ready`=0 for 20 cycles → `out_valid` and `out_data` stay stable, `in_ready`=0, and a pulsed `in_valid` is ignored. After `out_ready`=1, `in_ready` rises the next cycle.
- `clr` at MAC cycle 3 with nonzero history → IDLE next cycle, no `out_valid`. The next pass-through vector 50 with b1=16384 (x1 tap) outputs 0.
- `reset` asserted mid-MAC → `out_valid`=0 and `out_data`=0 immediately. After release, `in_ready`=1 and filtering restarts from zero history.
